bof_range_ctrl: RTL and testbench
=================================

Name: bof_range_ctrl

Overview:
- Controller that sequences the overflow-range circular buffer (circular_buffer_om) alongside the branch unit.
- Watches the issued memory and jump stream and tracks runs of contiguous non-stack stores.
- Commits qualifying runs (longer than a threshold) to the range buffer through a valid/ready write port.
- Raises a one-shot crash request when a JALR follows a load from a tracked or stored range.

Parameters:
ADDR_W, 32, address/vaddr width
MIN_RUN_BYTES, 32, run is committed only if byte count > this value
TIMEOUT, 10, non-store instructions tolerated before an open run closes

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rst_us_i  in  1  synchronous flush (user buffer reset)
en_i  in  1  crash enable; gates crash_o only
instr_valid_i  in  1  instruction fields below valid this cycle
is_store_i  in  1  SW/SH/SB
store_size_i  in  3  store bytes: 1, 2 or 4
is_load_i  in  1  LW
is_jalr_i  in  1  JALR
rs1_i  in  5  base register index
vaddr_i  in  ADDR_W  effective address (operand_a + imm)
addr_in_buf_i  in  1  buffer lookup hit for vaddr_i (combinational from buffer)
buf_wr_valid_o  out  1  commit request to buffer
buf_wr_ready_i  in  1  buffer accepts commit
buf_first_o  out  ADDR_W  first byte of committed range
buf_last_o  out  ADDR_W  last byte of committed range (inclusive)
active_o  out  1  state == TRACK
run_count_o  out  ADDR_W  byte count of current/last run
crash_o  out  1  one-cycle crash request

Behaviour:
- Reset (rst_ni low): state IDLE; all outputs 0; start_q, next_q, count_q, taint_q 0; timer_q = TIMEOUT.
- Tracked store: instr_valid_i && is_store_i && rs1_i not in {2, 8}. Stack stores (rs1 = sp/fp) are fully ignored: no state or timer change.
- Non-store: instr_valid_i && !is_store_i.
- next_q holds the exclusive end of the run. buf_last_o = next_q - 1. buf_first_o = start_q.
- IDLE:
  - On a tracked store: go to TRACK. start_q = vaddr_i; next_q = vaddr_i + size; count_q = size; timer_q = TIMEOUT.
- TRACK:
  - Contiguous store (vaddr_i == next_q, and vaddr_i + size does not overflow 2^ADDR_W): next_q += size; count_q += size; timer_q = TIMEOUT.
  - Non-contiguous store, or contiguous store that would wrap:
    - If count_q > MIN_RUN_BYTES: go to COMMIT. The terminating store is not tracked.
    - Otherwise: restart the run immediately with that store, exactly as from IDLE.
  - Non-store with timer_q != 0: timer_q decrements.
  - Non-store with timer_q == 0: go to COMMIT if count_q > MIN_RUN_BYTES, else go to IDLE.
- COMMIT:
  - buf_wr_valid_o = 1. start_q, next_q and count_q are held stable until buf_wr_ready_i.
  - Transfer cycle (valid && ready): go to IDLE next cycle; valid drops.
  - Stores are ignored in COMMIT.
- Taint (active in every state):
  - On a valid load: taint_q <= addr_in_buf_i || (state == TRACK && start_q <= vaddr_i <= next_q - 1).
  - On a valid JALR: crash_o <= taint_q && en_i (registered, one-cycle pulse); taint_q <= 0.
  - Other instructions leave taint_q unchanged.
- If load and JALR flags are both set in one cycle, the JALR rule wins.
- count_q saturates at all-ones; it never wraps.
- rst_us_i (synchronous, priority over everything except rst_ni):
  - Next state IDLE; taint_q and crash_o cleared; timer_q = TIMEOUT.
  - A pending commit is dropped; buf_wr_valid_o is low next cycle.
- run_count_o = count_q, held after the run closes until the next run starts.
- No combinational path from instruction inputs to any output. All outputs are registered or decoded from state.

Test Plan:
- Nine SW at 0x1000, 0x1004 … 0x1020 (36 B), then SW to 0x5000 → COMMIT. buf_wr_valid_o = 1, first = 0x1000, last = 0x1023, run_count_o = 36. Ready high → IDLE next cycle.
- Same run with buf_wr_ready_i low for 3 cycles → valid, first and last stable for all 3 cycles. Stores at 0x6000 during the stall are ignored. Transfer on the 4th cycle.
- Eight SW (32 B) then 11 ADDs → no commit; IDLE after the 11th ADD.
- Nine SW then exactly 10 ADDs → still TRACK; SW at 0x1024 extends the run to 40 B.
- Nine SW, then a load with vaddr 0x1010 in TRACK, then JALR → crash_o = 1 for exactly one cycle. Repeat with en_i = 0 → crash_o stays 0.
- SW via rs1 = 2 at 0x1024 mid-run → ignored (timer unchanged). SB at 0xFFFFFFFF while next_q = 0xFFFFFFFF → terminates the run. rst_us_i asserted during COMMIT → valid low next cycle, state IDLE.

Source files
------------

// File: rtl/bof_range_ctrl_if.sv
// Commit port between the overflow-range controller and the range circular buffer.
// The controller drives the range and valid; the buffer answers with ready.
interface bof_range_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              buf_wr_valid_o;
  logic              buf_wr_ready_i;
  logic [ADDR_W-1:0] buf_first_o;
  logic [ADDR_W-1:0] buf_last_o;

  modport master (
    output buf_wr_valid_o,
    output buf_first_o,
    output buf_last_o,
    input  buf_wr_ready_i
  );

  modport slave (
    input  buf_wr_valid_o,
    input  buf_first_o,
    input  buf_last_o,
    output buf_wr_ready_i
  );
endinterface

// File: rtl/bof_range_ctrl.sv
// Tracks runs of contiguous non-stack stores, commits long runs to the range buffer,
// and requests a crash when a JALR follows a load from a tracked or buffered range.
module bof_range_ctrl #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned MIN_RUN_BYTES = 32,
  parameter int unsigned TIMEOUT       = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rst_us_i,
  input  logic              en_i,
  input  logic              instr_valid_i,
  input  logic              is_store_i,
  input  logic [2:0]        store_size_i,
  input  logic              is_load_i,
  input  logic              is_jalr_i,
  input  logic [4:0]        rs1_i,
  input  logic [ADDR_W-1:0] vaddr_i,
  input  logic              addr_in_buf_i,
  bof_range_ctrl_if.master  buf_if,
  output logic              active_o,
  output logic [ADDR_W-1:0] run_count_o,
  output logic              crash_o
);

  localparam int unsigned   TW         = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] next_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] count_q;
  logic [TW-1:0]     timer_q;
  logic              taint_q;
  logic              crash_q;
  logic              valid_q;
  logic              active_q;

  logic [ADDR_W-1:0] size_ext;
  logic [ADDR_W:0]   end_sum;
  logic [ADDR_W:0]   cnt_sum;
  logic [ADDR_W-1:0] cnt_sat;
  logic [ADDR_W-1:0] end_last;
  logic              tracked_st;
  logic              non_store;
  logic              contiguous;
  logic              run_long;
  logic              in_range;
  logic              start_run;
  logic              ext_run;
  logic              timer_out;

  // The wider sums expose a run end that would wrap past the top of the address space.
  assign size_ext   = ADDR_W'(store_size_i);
  assign end_sum    = {1'b0, vaddr_i} + {1'b0, size_ext};
  assign cnt_sum    = {1'b0, count_q} + {1'b0, size_ext};
  assign cnt_sat    = cnt_sum[ADDR_W] ? '1 : cnt_sum[ADDR_W-1:0];
  assign end_last   = end_sum[ADDR_W-1:0] - ADDR_W'(1);

  assign tracked_st = instr_valid_i && is_store_i && (rs1_i != 5'd2) && (rs1_i != 5'd8);
  assign non_store  = instr_valid_i && !is_store_i;
  assign contiguous = (vaddr_i == next_q) && !end_sum[ADDR_W];
  assign run_long   = count_q > ADDR_W'(MIN_RUN_BYTES);
  assign in_range   = (state_q == TRACK) && (vaddr_i >= start_q) && (vaddr_i <= last_q);
  assign timer_out  = non_store && (timer_q == '0);

  assign start_run  = tracked_st &&
                      ((state_q == IDLE) || ((state_q == TRACK) && !contiguous && !run_long));
  assign ext_run    = (state_q == TRACK) && tracked_st && contiguous;

  // Run bookkeeping, state sequencing and taint tracking share one register process.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      start_q  <= '0;
      next_q   <= '0;
      last_q   <= '0;
      count_q  <= '0;
      timer_q  <= TIMER_INIT;
      taint_q  <= 1'b0;
      crash_q  <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else if (rst_us_i) begin
      state_q  <= IDLE;
      timer_q  <= TIMER_INIT;
      taint_q  <= 1'b0;
      crash_q  <= 1'b0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      crash_q <= 1'b0;
      if (instr_valid_i && is_jalr_i) begin
        crash_q <= taint_q && en_i;
        taint_q <= 1'b0;
      end else if (instr_valid_i && is_load_i) begin
        taint_q <= addr_in_buf_i || in_range;
      end

      if (start_run) begin
        start_q <= vaddr_i;
        next_q  <= end_sum[ADDR_W-1:0];
        last_q  <= end_last;
        count_q <= size_ext;
        timer_q <= TIMER_INIT;
      end else if (ext_run) begin
        next_q  <= end_sum[ADDR_W-1:0];
        last_q  <= end_last;
        count_q <= cnt_sat;
        timer_q <= TIMER_INIT;
      end else if ((state_q == TRACK) && non_store && (timer_q != '0)) begin
        timer_q <= timer_q - TW'(1);
      end

      case (state_q)
        IDLE: begin
          if (tracked_st) begin
            state_q  <= TRACK;
            active_q <= 1'b1;
          end
        end
        TRACK: begin
          if (run_long && ((tracked_st && !contiguous) || timer_out)) begin
            state_q  <= COMMIT;
            active_q <= 1'b0;
            valid_q  <= 1'b1;
          end else if (timer_out) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end
        COMMIT: begin
          if (buf_if.buf_wr_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign buf_if.buf_wr_valid_o = valid_q;
  assign buf_if.buf_first_o    = start_q;
  assign buf_if.buf_last_o     = last_q;
  assign active_o              = active_q;
  assign run_count_o           = count_q;
  assign crash_o               = crash_q;

endmodule

// File: tb/tb_bof_range_ctrl.sv
// Directed bench for bof_range_ctrl: stimulus pushes expected commits/crashes into a
// scoreboard queue that an independent negedge monitor drains.
module tb_bof_range_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rst_us_i;
  logic        en_i;
  logic        instr_valid_i;
  logic        is_store_i;
  logic [2:0]  store_size_i;
  logic        is_load_i;
  logic        is_jalr_i;
  logic [4:0]  rs1_i;
  logic [31:0] vaddr_i;
  logic        addr_in_buf_i;
  logic        active_o;
  logic [31:0] run_count_o;
  logic        crash_o;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_crash;
    logic [31:0] first;
    logic [31:0] last;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];

  bof_range_ctrl_if #(.ADDR_W(32)) bus ();

  bof_range_ctrl #(
    .ADDR_W(32),
    .MIN_RUN_BYTES(32),
    .TIMEOUT(10)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .rst_us_i(rst_us_i),
    .en_i(en_i),
    .instr_valid_i(instr_valid_i),
    .is_store_i(is_store_i),
    .store_size_i(store_size_i),
    .is_load_i(is_load_i),
    .is_jalr_i(is_jalr_i),
    .rs1_i(rs1_i),
    .vaddr_i(vaddr_i),
    .addr_in_buf_i(addr_in_buf_i),
    .buf_if(bus),
    .active_o(active_o),
    .run_count_o(run_count_o),
    .crash_o(crash_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one instruction for exactly one capturing edge, then returns at edge+1.
  task automatic applyStimulus(input logic st, input logic [2:0] sz, input logic ld, input logic jr,
                               input logic [4:0] rs1, input logic [31:0] va, input logic hit);
    instr_valid_i = 1'b1;
    is_store_i    = st;
    store_size_i  = sz;
    is_load_i     = ld;
    is_jalr_i     = jr;
    rs1_i         = rs1;
    vaddr_i       = va;
    addr_in_buf_i = hit;
    @(posedge clk_i);
    #1;
    instr_valid_i = 1'b0;
    is_store_i    = 1'b0;
    is_load_i     = 1'b0;
    is_jalr_i     = 1'b0;
    addr_in_buf_i = 1'b0;
  endtask

  task automatic sw(input logic [31:0] a);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 5'd10, a, 1'b0);
  endtask

  task automatic alu();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 5'd1, 32'h0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic hit);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 5'd10, a, hit);
  endtask

  task automatic jalr();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 5'd1, 32'h0, 1'b0);
  endtask

  task automatic idle_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sw_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sw(base + 32'(4 * i));
  endtask

  task automatic expect_commit(input logic [31:0] f, input logic [31:0] l, input logic [31:0] c);
    exp_t e;
    e.is_crash = 1'b0;
    e.first    = f;
    e.last     = l;
    e.count    = c;
    exp_q.push_back(e);
  endtask

  task automatic expect_crash();
    exp_t e;
    e.is_crash = 1'b1;
    e.first    = '0;
    e.last     = '0;
    e.count    = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every commit transfer and every crash pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1) begin
        if (bus.buf_wr_valid_o && bus.buf_wr_ready_i) begin
          if (exp_q.size() == 0 || exp_q[0].is_crash) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL commit_event: got transfer first=0x%08h last=0x%08h, expected none",
                     bus.buf_first_o, bus.buf_last_o);
          end else begin
            e = exp_q.pop_front();
            checkOutput("commit_first", bus.buf_first_o, e.first);
            checkOutput("commit_last", bus.buf_last_o, e.last);
            checkOutput("commit_count", run_count_o, e.count);
          end
        end
        if (crash_o) begin
          if (exp_q.size() == 0 || !exp_q[0].is_crash) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL crash_event: got crash_o=1, expected 0");
          end else begin
            e = exp_q.pop_front();
            checkOutput("crash_pulse", 32'(crash_o), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    rst_ni             = 1'b0;
    rst_us_i           = 1'b0;
    en_i               = 1'b1;
    instr_valid_i      = 1'b0;
    is_store_i         = 1'b0;
    store_size_i       = 3'd0;
    is_load_i          = 1'b0;
    is_jalr_i          = 1'b0;
    rs1_i              = 5'd0;
    vaddr_i            = 32'h0;
    addr_in_buf_i      = 1'b0;
    bus.buf_wr_ready_i = 1'b1;

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_valid", 32'(bus.buf_wr_valid_o), 32'd0);
    checkOutput("reset_first", bus.buf_first_o, 32'h0);
    checkOutput("reset_last", bus.buf_last_o, 32'h0);
    checkOutput("reset_count", run_count_o, 32'h0);
    checkOutput("reset_active", 32'(active_o), 32'd0);
    checkOutput("reset_crash", 32'(crash_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_cycle();

    // 36-byte run closed by a distant store, accepted immediately.
    sw_run(32'h1000, 9);
    checkOutput("run36_active", 32'(active_o), 32'd1);
    checkOutput("run36_count", run_count_o, 32'd36);
    checkOutput("run36_last", bus.buf_last_o, 32'h1023);
    expect_commit(32'h1000, 32'h1023, 32'd36);
    sw(32'h5000);
    checkOutput("commit_valid", 32'(bus.buf_wr_valid_o), 32'd1);
    idle_cycle();
    checkOutput("after_xfer_valid", 32'(bus.buf_wr_valid_o), 32'd0);
    checkOutput("after_xfer_active", 32'(active_o), 32'd0);

    // Same run with a three-cycle stall; stores during the stall are ignored.
    bus.buf_wr_ready_i = 1'b0;
    sw_run(32'h1000, 9);
    expect_commit(32'h1000, 32'h1023, 32'd36);
    sw(32'h5000);
    checkOutput("stall_valid0", 32'(bus.buf_wr_valid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      sw(32'h6000);
      checkOutput("stall_valid", 32'(bus.buf_wr_valid_o), 32'd1);
      checkOutput("stall_first", bus.buf_first_o, 32'h1000);
      checkOutput("stall_last", bus.buf_last_o, 32'h1023);
    end
    bus.buf_wr_ready_i = 1'b1;
    idle_cycle();
    checkOutput("stall_done_valid", 32'(bus.buf_wr_valid_o), 32'd0);
    checkOutput("stall_done_active", 32'(active_o), 32'd0);
    checkOutput("stall_done_count", run_count_o, 32'd36);

    // 32-byte run is not long enough; it times out on the 11th non-store.
    sw_run(32'h2000, 8);
    repeat (10) alu();
    checkOutput("short_alive", 32'(active_o), 32'd1);
    alu();
    checkOutput("short_idle", 32'(active_o), 32'd0);
    checkOutput("short_no_commit", 32'(bus.buf_wr_valid_o), 32'd0);
    checkOutput("short_count", run_count_o, 32'd32);

    // Exactly ten non-stores keep the run open; it then extends to 40 bytes.
    sw_run(32'h1000, 9);
    repeat (10) alu();
    checkOutput("ten_alive", 32'(active_o), 32'd1);
    sw(32'h1024);
    checkOutput("ext_count", run_count_o, 32'd40);
    checkOutput("ext_last", bus.buf_last_o, 32'h1027);
    expect_commit(32'h1000, 32'h1027, 32'd40);
    sw(32'h7000);
    idle_cycle();
    checkOutput("ext_done_valid", 32'(bus.buf_wr_valid_o), 32'd0);

    // Load inside the open run taints; JALR fires one pulse only when enabled.
    sw_run(32'h1000, 9);
    en_i = 1'b1;
    ld(32'h1010, 1'b0);
    expect_crash();
    jalr();
    checkOutput("crash_on", 32'(crash_o), 32'd1);
    idle_cycle();
    checkOutput("crash_one_shot", 32'(crash_o), 32'd0);
    en_i = 1'b0;
    ld(32'h1010, 1'b0);
    jalr();
    checkOutput("crash_disabled", 32'(crash_o), 32'd0);
    en_i = 1'b1;

    // Stack store mid-run changes nothing: six more non-stores drain the timer.
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 5'd2, 32'h1024, 1'b0);
    checkOutput("stack_count", run_count_o, 32'd36);
    repeat (6) alu();
    checkOutput("stack_timer_alive", 32'(active_o), 32'd1);
    expect_commit(32'h1000, 32'h1023, 32'd36);
    alu();
    checkOutput("timeout_commit", 32'(bus.buf_wr_valid_o), 32'd1);
    idle_cycle();

    // Run ending at the top of the address space; an SB that would wrap closes it.
    bus.buf_wr_ready_i = 1'b0;
    sw_run(32'hFFFF_FFDB, 9);
    checkOutput("top_last", bus.buf_last_o, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 5'd10, 32'hFFFF_FFFF, 1'b0);
    checkOutput("wrap_commit", 32'(bus.buf_wr_valid_o), 32'd1);
    checkOutput("wrap_active", 32'(active_o), 32'd0);
    rst_us_i = 1'b1;
    idle_cycle();
    rst_us_i = 1'b0;
    checkOutput("flush_valid", 32'(bus.buf_wr_valid_o), 32'd0);
    checkOutput("flush_active", 32'(active_o), 32'd0);
    bus.buf_wr_ready_i = 1'b1;
    idle_cycle();
    checkOutput("flush_dropped", 32'(bus.buf_wr_valid_o), 32'd0);

    // Buffer hit taints from IDLE; flush clears taint; JALR beats a same-cycle load.
    ld(32'h9000, 1'b1);
    expect_crash();
    jalr();
    checkOutput("hit_crash", 32'(crash_o), 32'd1);
    idle_cycle();
    ld(32'h9000, 1'b1);
    rst_us_i = 1'b1;
    idle_cycle();
    rst_us_i = 1'b0;
    jalr();
    checkOutput("flush_untaint", 32'(crash_o), 32'd0);
    ld(32'h9000, 1'b1);
    expect_crash();
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 5'd10, 32'h9000, 1'b1);
    checkOutput("ld_jalr_crash", 32'(crash_o), 32'd1);
    jalr();
    checkOutput("ld_jalr_cleared", 32'(crash_o), 32'd0);

    repeat (2) idle_cycle();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
